// File: rtl/ro_freq_compare.sv
// RO PUF frequency comparator: synchronizes two selected ring oscillators, counts their
// rising edges over a fixed gate window and emits one response bit per measurement.
module ro_freq_compare #(
  parameter int CNT_W       = 16,
  parameter int WINDOW      = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             ro_a_i,
  input  logic             ro_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             puf_bit_o,
  output logic             tie_o,
  output logic [CNT_W-1:0] cnt_a_o,
  output logic [CNT_W-1:0] cnt_b_o
);

  // state    | meaning
  // S_IDLE   | waiting for start_i
  // S_SETTLE | SYNC_STAGES+1 cycles, counters held at 0 while synchronizers flush
  // S_COUNT  | WINDOW cycles, counting rising edges of both oscillators
  // S_COMPARE| one cycle, latch counts and comparison result
  // S_DONE   | one cycle, done_o pulse
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_COUNT, S_COMPARE, S_DONE} state_t;

  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam int SET_W = $clog2(SYNC_STAGES + 2);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync_a;
  logic [SYNC_STAGES-1:0] r_sync_b;
  logic                   r_prev_a;
  logic                   r_prev_b;
  logic [SET_W-1:0]       r_settle_cnt;
  logic [WIN_W-1:0]       r_win_cnt;
  logic [CNT_W-1:0]       r_cnt_a;
  logic [CNT_W-1:0]       r_cnt_b;
  logic                   w_rise_a;
  logic                   w_rise_b;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
      r_prev_a <= 1'b0;
      r_prev_b <= 1'b0;
    end else begin
      r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], ro_a_i};
      r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], ro_b_i};
      r_prev_a <= r_sync_a[SYNC_STAGES-1];
      r_prev_b <= r_sync_b[SYNC_STAGES-1];
    end
  end

  assign w_rise_a = r_sync_a[SYNC_STAGES-1] & ~r_prev_a;
  assign w_rise_b = r_sync_b[SYNC_STAGES-1] & ~r_prev_b;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_win_cnt    <= '0;
      r_cnt_a      <= '0;
      r_cnt_b      <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      puf_bit_o    <= 1'b0;
      tie_o        <= 1'b0;
      cnt_a_o      <= '0;
      cnt_b_o      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state      <= S_SETTLE;
            r_settle_cnt <= SET_LAST;
            busy_o       <= 1'b1;
          end
        end
        S_SETTLE: begin
          r_cnt_a <= '0;
          r_cnt_b <= '0;
          if (r_settle_cnt == '0) begin
            r_state   <= S_COUNT;
            r_win_cnt <= '0;
          end else begin
            r_settle_cnt <= r_settle_cnt - SET_W'(1);
          end
        end
        S_COUNT: begin
          // saturate rather than wrap so a fast oscillator can never look slow
          if (w_rise_a && (r_cnt_a != CNT_MAX)) r_cnt_a <= r_cnt_a + CNT_W'(1);
          if (w_rise_b && (r_cnt_b != CNT_MAX)) r_cnt_b <= r_cnt_b + CNT_W'(1);
          if (r_win_cnt == WIN_LAST) begin
            r_state <= S_COMPARE;
          end else begin
            r_win_cnt <= r_win_cnt + WIN_W'(1);
          end
        end
        S_COMPARE: begin
          cnt_a_o   <= r_cnt_a;
          cnt_b_o   <= r_cnt_b;
          puf_bit_o <= (r_cnt_a > r_cnt_b);
          tie_o     <= (r_cnt_a == r_cnt_b);
          busy_o    <= 1'b0;
          done_o    <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          done_o  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_freq_compare.sv
// Directed bench for ro_freq_compare: main DUT with 16-bit counters, a second one with
// 4-bit counters for saturation; oscillators are modelled as divided clocks.
module tb_ro_freq_compare;

  localparam int WINDOW = 64;
  localparam int SYNC   = 2;
  localparam int LAT    = SYNC + WINDOW + 3;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic        ro_a = 1'b0;
  logic        ro_b = 1'b0;
  logic        busy, done, puf, tie;
  logic [15:0] cnt_a, cnt_b;
  logic        busy4, done4, puf4, tie4;
  logic [3:0]  cnt_a4, cnt_b4;

  int ha = 0, hb = 0;
  bit same_src = 1'b0;
  int n_cmp = 0, n_bad = 0;

  ro_freq_compare #(.CNT_W(16), .WINDOW(WINDOW), .SYNC_STAGES(SYNC)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .ro_a_i(ro_a), .ro_b_i(ro_b),
    .busy_o(busy), .done_o(done), .puf_bit_o(puf), .tie_o(tie),
    .cnt_a_o(cnt_a), .cnt_b_o(cnt_b));

  ro_freq_compare #(.CNT_W(4), .WINDOW(WINDOW), .SYNC_STAGES(SYNC)) dut4 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .ro_a_i(ro_a), .ro_b_i(ro_b),
    .busy_o(busy4), .done_o(done4), .puf_bit_o(puf4), .tie_o(tie4),
    .cnt_a_o(cnt_a4), .cnt_b_o(cnt_b4));

  initial forever #5 clk_i = ~clk_i;

  // oscillator model: each toggles every ha / hb clock cycles (half period)
  initial begin
    int ca, cb;
    ca = 0;
    cb = 0;
    forever begin
      @(negedge clk_i);
      if (ha > 0) begin
        ca++;
        if (ca >= ha) begin ca = 0; ro_a = ~ro_a; end
      end
      if (hb > 0) begin
        cb++;
        if (cb >= hb) begin cb = 0; ro_b = ~ro_b; end
      end
      if (same_src) ro_b = ro_a;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // cycle 1 begins at the edge that samples start_i; returns the cycle in which done_o is high
  task automatic meas(output int cyc);
    @(negedge clk_i) start_i = 1'b1;
    @(posedge clk_i) #1 start_i = 1'b0;
    cyc = 1;
    chk("busy_on_accept", busy, 1);
    while (!done && cyc < 300) begin
      @(posedge clk_i) #1;
      cyc++;
    end
    if (!done) chk("done_timeout", 0, 1);
    chk("busy_in_done", busy, 0);
  endtask

  task automatic pulse_width_chk();
    @(posedge clk_i) #1;
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    int lat, nd, d1, d2;

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_puf", puf, 0);
    chk("rst_tie", tie, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_cnt_b", cnt_b, 0);
    @(negedge clk_i) rst_n_i = 1'b1;

    // A period 4, B period 6
    ha = 2; hb = 3;
    repeat (10) @(posedge clk_i);
    meas(lat);
    chk("s1_latency", lat, LAT);
    chk("s1_cnt_a", cnt_a, 16);
    chk("s1_cnt_b_10_or_11", (cnt_b == 16'd10) || (cnt_b == 16'd11), 1);
    chk("s1_puf", puf, 1);
    chk("s1_tie", tie, 0);
    pulse_width_chk();

    // swapped
    ha = 3; hb = 2;
    repeat (10) @(posedge clk_i);
    meas(lat);
    chk("s2_cnt_b", cnt_b, 16);
    chk("s2_cnt_a_10_or_11", (cnt_a == 16'd10) || (cnt_a == 16'd11), 1);
    chk("s2_puf", puf, 0);
    chk("s2_tie", tie, 0);

    // common period-8 source
    ha = 4; hb = 0; same_src = 1'b1;
    repeat (10) @(posedge clk_i);
    meas(lat);
    chk("s3_cnt_a", cnt_a, 8);
    chk("s3_cnt_b", cnt_b, 8);
    chk("s3_tie", tie, 1);
    chk("s3_puf", puf, 0);

    // 4-bit counters: A period 2 saturates at 15
    same_src = 1'b0; ha = 1; hb = 4;
    repeat (10) @(posedge clk_i);
    meas(lat);
    chk("s4_done4", done4, 1);
    chk("s4_busy4", busy4, 0);
    chk("s4_cnt_a4_sat", cnt_a4, 15);
    chk("s4_cnt_b4", cnt_b4, 8);
    chk("s4_puf4", puf4, 1);
    chk("s4_tie4", tie4, 0);

    // reset in the middle of COUNT
    ha = 2; hb = 3;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i) start_i = 1'b1;
    @(posedge clk_i) #1 start_i = 1'b0;
    repeat (30) @(posedge clk_i);
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_puf", puf, 0);
    chk("arst_tie", tie, 0);
    chk("arst_cnt_a", cnt_a, 0);
    chk("arst_cnt_b", cnt_b, 0);
    @(posedge clk_i) #2 rst_n_i = 1'b1;
    nd = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_i) #1;
      if (done) nd++;
    end
    chk("no_done_after_rst", nd, 0);
    meas(lat);
    chk("rr_latency", lat, LAT);
    chk("rr_cnt_a", cnt_a, 16);
    chk("rr_cnt_b_10_or_11", (cnt_b == 16'd10) || (cnt_b == 16'd11), 1);
    chk("rr_puf", puf, 1);
    chk("rr_tie", tie, 0);

    // start while busy is ignored; start held through DONE restarts after one IDLE cycle
    repeat (10) @(posedge clk_i);
    @(negedge clk_i) start_i = 1'b1;
    @(posedge clk_i) #1 start_i = 1'b0;
    nd = 0; d1 = 0; d2 = 0;
    for (int i = 1; i < 200; i++) begin
      @(posedge clk_i) #1;
      if (i == 10) start_i = 1'b1;
      if (i == 11) start_i = 1'b0;
      if (i == 60) start_i = 1'b1;
      if (done) begin
        nd++;
        if (d1 == 0) begin
          d1 = i;
          ha = 3; hb = 2;
        end else if (d2 == 0) begin
          d2 = i;
        end
      end
      if (d1 != 0 && i == d1 + 1) begin
        chk("idle_gap_busy", busy, 0);
        chk("idle_gap_cnt_a_hold", cnt_a, 16);
      end
      if (d1 != 0 && i == d1 + 2) begin
        chk("restart_busy", busy, 1);
        chk("restart_puf_hold", puf, 1);
        start_i = 1'b0;
      end
      if (d1 != 0 && i == d1 + 40) begin
        chk("mid_cnt_a_hold", cnt_a, 16);
        chk("mid_puf_hold", puf, 1);
      end
    end
    chk("first_done_cycle", d1 + 1, LAT);
    chk("done_spacing", d2 - d1, LAT + 1);
    chk("done_count", nd, 2);
    chk("m2_cnt_b", cnt_b, 16);
    chk("m2_puf", puf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ro_freq_compare.md
Name: ro_freq_compare

Overview:
- Downstream consumer of the two 16:1 ring-oscillator select muxes in the RO PUF.
- Takes the two selected oscillator outputs, synchronizes them into the clock domain, and counts rising edges of each over a fixed gate window.
- Compares the two counts and emits one response bit per challenge, with a start/done handshake to the challenge sequencer.

Parameters:
- CNT_W, 16, width of each edge counter and count output.
- WINDOW, 1024, gate window length in clk_i cycles; must be >= 1.
- SYNC_STAGES, 2, flip-flop stages in each oscillator synchronizer; must be >= 2.

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  asynchronous active-low reset.
- start_i  input  1  request one measurement; sampled only in IDLE.
- ro_a_i  input  1  selected oscillator A; asynchronous to clk_i.
- ro_b_i  input  1  selected oscillator B; asynchronous to clk_i.
- busy_o  output  1  high from the start acceptance until done_o.
- done_o  output  1  one-cycle pulse; results are valid in this cycle and afterwards.
- puf_bit_o  output  1  response bit: 1 if count A > count B, else 0.
- tie_o  output  1  counts were equal; the bit is unreliable.
- cnt_a_o  output  CNT_W  final edge count of A.
- cnt_b_o  output  CNT_W  final edge count of B.

Behaviour:
- Clock and reset: one clock, clk_i. rst_n_i is asynchronous and active-low. On assertion, all state clears immediately:
  - FSM goes to IDLE.
  - Synchronizers, edge-detect registers and counters clear.
  - busy_o=0, done_o=0, puf_bit_o=0, tie_o=0, cnt_a_o=0, cnt_b_o=0.
  - Reset mid-measurement discards that measurement; no done_o is produced.
- Synchronizer: each ro_*_i passes through a SYNC_STAGES flop chain. One further register holds the previous synchronized value. A rising edge is detected when the synchronized value is 1 and the previous value is 0.
- FSM states:
  - IDLE: busy_o=0. start_i=1 moves to SETTLE.
  - SETTLE: lasts SYNC_STAGES+1 cycles. Edge counters are held at 0 so stale synchronizer contents are flushed. Then moves to COUNT.
  - COUNT: lasts exactly WINDOW cycles. Each counter increments by 1 in every cycle its edge detect is high.
  - COMPARE: lasts 1 cycle. Registers cnt_a_o, cnt_b_o, puf_bit_o = (A > B) and tie_o = (A == B). Then moves to DONE.
  - DONE: lasts 1 cycle. done_o=1, busy_o=0. Then moves to IDLE.
- busy_o is 1 in SETTLE, COUNT and COMPARE.
- Latency: done_o is high exactly SYNC_STAGES+WINDOW+3 cycles after the edge that sampled start_i in IDLE.
- start_i is ignored outside IDLE. A start_i held high in DONE is not accepted until the IDLE cycle that follows. Continuous start_i therefore yields back-to-back measurements with one IDLE cycle between them.
- Counter width rules:
  - Edge counters saturate at 2^CNT_W-1 and never wrap.
  - If both counters saturate, tie_o=1 and puf_bit_o=0.
  - The window counter is sized $clog2(WINDOW+1) bits and counts 0..WINDOW-1.
- Result outputs (puf_bit_o, tie_o, cnt_*_o) hold their values until the next COMPARE; they do not change when a new start is accepted.
- Validity bound: counts are exact only for oscillator periods greater than 2 clk_i periods. Faster oscillators alias, and that is outside the scope of this block.
- Edge cases:
  - An edge that arrives simultaneously with the COUNT->COMPARE transition is not counted.
  - An edge detected in the first COUNT cycle is counted.

Test Plan:
- WINDOW=64, SYNC_STAGES=2, CNT_W=16. ro_a_i toggles every 2 clk (period 4), ro_b_i toggles every 3 clk (period 6). Pulse start_i. Required: done_o exactly 69 cycles later, cnt_a_o=16, cnt_b_o in {10,11}, puf_bit_o=1, tie_o=0.
- Swap the A and B stimuli of the first scenario. Required: puf_bit_o=0, tie_o=0, cnt_b_o=16.
- ro_a_i and ro_b_i driven from the same period-8 source. Required: cnt_a_o = cnt_b_o = 8, tie_o=1, puf_bit_o=0.
- CNT_W=4, WINDOW=64, ro_a_i period 2, ro_b_i period 8. Required: cnt_a_o=15 (saturated, no wrap), cnt_b_o=8, puf_bit_o=1.
- Assert rst_n_i low for 1 cycle during COUNT (cycle 30 after start). Required: all outputs 0 immediately and asynchronously, no done_o. A new start then produces a full-latency result identical to the first scenario.
- Pulse start_i again while busy_o=1. Required: ignored, exactly one done_o. Then hold start_i high across DONE. Required: the next measurement begins from the following IDLE cycle, and the previous results hold until its COMPARE.
